// File: rtl/load_buffer_pkg.sv
// load_buffer_pkg: shared widths, load opcodes, memory size codes and buffer state type.
package load_buffer_pkg;
  localparam int IDWidth       = 32;
  localparam int ROBWidth      = 4;
  localparam int AddressWidth  = 32;
  localparam int InstTypeWidth = 6;
  localparam int LBCount       = 4;
  localparam logic [InstTypeWidth-1:0] LB  = 6'd11;
  localparam logic [InstTypeWidth-1:0] LH  = 6'd12;
  localparam logic [InstTypeWidth-1:0] LW  = 6'd13;
  localparam logic [InstTypeWidth-1:0] LBU = 6'd14;
  localparam logic [InstTypeWidth-1:0] LHU = 6'd15;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} lb_state_e;
  function automatic logic [1:0] mem_size(input logic [InstTypeWidth-1:0] op);
    return (op == LB || op == LBU) ? SIZE_BYTE : (op == LH || op == LHU) ? SIZE_HALF : SIZE_WORD;
  endfunction
endpackage

// File: rtl/load_buffer_if.sv
// load_buffer_if: address-unit, memory-controller, ROB flush and CDB signals of the load buffer.
interface load_buffer_if #(
  parameter int ROB_WIDTH  = load_buffer_pkg::ROBWidth,
  parameter int DATA_WIDTH = load_buffer_pkg::IDWidth,
  parameter int ADDR_WIDTH = load_buffer_pkg::AddressWidth,
  parameter int OP_WIDTH   = load_buffer_pkg::InstTypeWidth
);
  logic                  addrunit_lbuffer_en_in;
  logic [ADDR_WIDTH-1:0] addrunit_lbuffer_addr_in;
  logic [ROB_WIDTH-1:0]  addrunit_lbuffer_dest_in;
  logic [OP_WIDTH-1:0]   addrunit_lbuffer_opcode_in;
  logic                  lbuffer_rs_rdy_out;
  logic                  lbuffer_memctrl_en_out;
  logic [ADDR_WIDTH-1:0] lbuffer_memctrl_addr_out;
  logic [1:0]            lbuffer_memctrl_size_out;
  logic                  memctrl_lbuffer_rdy_in;
  logic [DATA_WIDTH-1:0] memctrl_lbuffer_data_in;
  logic                  rob_lbuffer_rst_in;
  logic [ROB_WIDTH-1:0]  cdb_lbuffer_b_out;
  logic [DATA_WIDTH-1:0] cdb_lbuffer_result_out;
  modport slave (
    input  addrunit_lbuffer_en_in, addrunit_lbuffer_addr_in, addrunit_lbuffer_dest_in,
           addrunit_lbuffer_opcode_in, memctrl_lbuffer_rdy_in, memctrl_lbuffer_data_in,
           rob_lbuffer_rst_in,
    output lbuffer_rs_rdy_out, lbuffer_memctrl_en_out, lbuffer_memctrl_addr_out,
           lbuffer_memctrl_size_out, cdb_lbuffer_b_out, cdb_lbuffer_result_out
  );
  modport master (
    output addrunit_lbuffer_en_in, addrunit_lbuffer_addr_in, addrunit_lbuffer_dest_in,
           addrunit_lbuffer_opcode_in, memctrl_lbuffer_rdy_in, memctrl_lbuffer_data_in,
           rob_lbuffer_rst_in,
    input  lbuffer_rs_rdy_out, lbuffer_memctrl_en_out, lbuffer_memctrl_addr_out,
           lbuffer_memctrl_size_out, cdb_lbuffer_b_out, cdb_lbuffer_result_out
  );
endinterface

// File: rtl/load_buffer_extend.sv
// load_extend: sign/zero extension of raw little-endian memory data by load opcode.
module load_extend import load_buffer_pkg::*; #(
  parameter int DATA_WIDTH = IDWidth,
  parameter int OP_WIDTH   = InstTypeWidth
) (
  input  logic [OP_WIDTH-1:0]   opcode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] result_o
);
  always_comb
    result_o = opcode_i == LB  ? {{(DATA_WIDTH-8){data_i[7]}}, data_i[7:0]} :
               opcode_i == LBU ? {{(DATA_WIDTH-8){1'b0}}, data_i[7:0]} :
               opcode_i == LH  ? {{(DATA_WIDTH-16){data_i[15]}}, data_i[15:0]} :
               opcode_i == LHU ? {{(DATA_WIDTH-16){1'b0}}, data_i[15:0]} : data_i;
endmodule

// File: rtl/load_buffer.sv
// load_buffer: in-order load queue issuing one memory read at a time and broadcasting results on the CDB.
module load_buffer import load_buffer_pkg::*; #(
  parameter int LB_DEPTH   = LBCount,
  parameter int ROB_WIDTH  = ROBWidth,
  parameter int DATA_WIDTH = IDWidth,
  parameter int ADDR_WIDTH = AddressWidth,
  parameter int OP_WIDTH   = InstTypeWidth
) (
  input logic         clk_in,
  input logic         rst_in,
  input logic         rdy_in,
  load_buffer_if.slave bus
);
  localparam int PW = $clog2(LB_DEPTH);
  logic [ADDR_WIDTH-1:0] addr_mem [LB_DEPTH];
  logic [ROB_WIDTH-1:0]  dest_mem [LB_DEPTH];
  logic [OP_WIDTH-1:0]   op_mem   [LB_DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [PW:0]           count_q, count_d;
  lb_state_e             state_q;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [ROB_WIDTH-1:0]  cdb_b_q;
  logic [DATA_WIDTH-1:0] cdb_res_q;
  logic                  flush, push, pop;
  logic [DATA_WIDTH-1:0] ext;
  load_extend #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH)) u_ext (
    .opcode_i(op_mem[head_q]),
    .data_i  (bus.memctrl_lbuffer_data_in),
    .result_o(ext)
  );
  always_comb begin
    flush   = bus.rob_lbuffer_rst_in;
    push    = bus.addrunit_lbuffer_en_in && !flush;
    pop     = state_q == WAIT_MEM && bus.memctrl_lbuffer_rdy_in && !flush;
    count_d = flush ? '0 : count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end
  always_ff @(posedge clk_in)
    if (rdy_in && push) begin
      addr_mem[tail_q] <= bus.addrunit_lbuffer_addr_in;
      dest_mem[tail_q] <= bus.addrunit_lbuffer_dest_in;
      op_mem[tail_q]   <= bus.addrunit_lbuffer_opcode_in;
    end
  // A flush mid-request parks in DRAIN: the controller still answers, and that answer is swallowed.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      en_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      cdb_b_q   <= '0;
      cdb_res_q <= '0;
    end else if (rdy_in) begin
      head_q  <= flush ? '0 : head_q + PW'(pop);
      tail_q  <= flush ? '0 : tail_q + PW'(push);
      count_q <= count_d;
      cdb_b_q <= '0;
      case (state_q)
        IDLE:
          if (count_q != '0 && !flush) begin
            en_q    <= 1'b1;
            addr_q  <= addr_mem[head_q];
            size_q  <= mem_size(op_mem[head_q]);
            state_q <= WAIT_MEM;
          end
        WAIT_MEM:
          if (bus.memctrl_lbuffer_rdy_in) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
            if (!flush) begin
              cdb_b_q   <= dest_mem[head_q];
              cdb_res_q <= ext;
            end
          end else if (flush) state_q <= DRAIN;
        DRAIN:
          if (bus.memctrl_lbuffer_rdy_in) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  // The spare second slot absorbs a load already in flight through the address unit.
  assign bus.lbuffer_rs_rdy_out       = count_q <= (PW+1)'(LB_DEPTH - 2);
  assign bus.lbuffer_memctrl_en_out   = en_q;
  assign bus.lbuffer_memctrl_addr_out = addr_q;
  assign bus.lbuffer_memctrl_size_out = size_q;
  assign bus.cdb_lbuffer_b_out        = cdb_b_q;
  assign bus.cdb_lbuffer_result_out   = cdb_res_q;
endmodule

// File: tb/tb_load_buffer.sv
// tb_load_buffer: randomized load traffic against a queue-based reference model with a CDB scoreboard.
module tb_load_buffer;
  import load_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int N_CYC = 700;
  localparam int N_QUIET = 90;
  typedef struct {logic [31:0] addr; logic [3:0] dest; logic [5:0] op;} ld_t;
  typedef struct {logic [3:0] tag; logic [31:0] val;} exp_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;
  logic edge_rdy = 1'b0;
  load_buffer_if bus ();
  load_buffer #(.LB_DEPTH(DEPTH)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) edge_rdy <= rdy_in;
  ld_t  ref_q [$];
  exp_t exp_q [$];
  int tests = 0;
  int fails = 0;
  logic [31:0] specials [5] = '{32'h0000_0080, 32'h0000_F001, 32'hDEAD_BEEF, 32'h0000_7FFF, 32'h0000_8000};
  logic [5:0]  ops [5] = '{LB, LH, LW, LBU, LHU};
  bit   mem_busy = 0, drain = 0;
  int   mem_cnt = 0, stall = 0;
  ld_t  cur;
  logic held_en;
  logic [3:0] held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [5:0] op, input logic [31:0] d);
    longint v;
    if (op == LB || op == LBU) v = longint'(d % 256);
    else if (op == LH || op == LHU) v = longint'(d % 65536);
    else return d;
    if (op == LB && v >= 128) v -= 256;
    if (op == LH && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  function automatic logic [1:0] model_size(input logic [5:0] op);
    case (op)
      LB, LBU: return 2'd0;
      LH, LHU: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  task automatic decide(input bit active, input bit may_stall);
    bit flush, mrdy, en;
    logic [31:0] data;
    ld_t n;
    check("rs_rdy", 32'(bus.lbuffer_rs_rdy_out), 32'((DEPTH - ref_q.size()) >= 2));
    if (mem_busy) check("en_held", 32'(bus.lbuffer_memctrl_en_out), 32'd1);
    else if (bus.lbuffer_memctrl_en_out) begin
      mem_busy = 1;
      mem_cnt = $urandom_range(1, 3);
      if (ref_q.size() == 0) check("req_on_empty", 32'(bus.lbuffer_memctrl_en_out), 32'd0);
      else begin
        cur = ref_q[0];
        check("req_addr", bus.lbuffer_memctrl_addr_out, cur.addr);
        check("req_size", 32'(bus.lbuffer_memctrl_size_out), 32'(model_size(cur.op)));
      end
    end
    mrdy = 0;
    data = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mrdy = 1;
        if ($urandom % 3 == 0) data = specials[$urandom % 5];
      end
    end
    flush = active && ($urandom % 20 == 0);
    en = active && ref_q.size() < DEPTH && ($urandom % 2 == 1);
    n.addr = $urandom;
    n.dest = 4'($urandom_range(1, 15));
    n.op = ops[$urandom % 5];
    if (mrdy) begin
      if (!flush && !drain) begin
        void'(ref_q.pop_front());
        exp_q.push_back('{tag: cur.dest, val: model_ext(cur.op, data)});
      end
      mem_busy = 0;
      drain = 0;
    end else if (flush && mem_busy) drain = 1;
    if (flush) ref_q.delete();
    else if (en) ref_q.push_back(n);
    bus.rob_lbuffer_rst_in = flush;
    bus.memctrl_lbuffer_rdy_in = mrdy;
    bus.memctrl_lbuffer_data_in = data;
    bus.addrunit_lbuffer_en_in = en;
    bus.addrunit_lbuffer_addr_in = n.addr;
    bus.addrunit_lbuffer_dest_in = n.dest;
    bus.addrunit_lbuffer_opcode_in = n.op;
    stall = (may_stall && $urandom % 8 == 0) ? $urandom_range(1, 3) : 0;
    rdy_in = (stall == 0);
    held_en = bus.lbuffer_memctrl_en_out;
    held_b = bus.cdb_lbuffer_b_out;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (edge_rdy && !rst_in && bus.cdb_lbuffer_b_out != '0) begin
        if (exp_q.size() == 0) check("cdb_unexpected", 32'(bus.cdb_lbuffer_b_out), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("cdb_tag", 32'(bus.cdb_lbuffer_b_out), 32'(e.tag));
          check("cdb_result", bus.cdb_lbuffer_result_out, e.val);
        end
      end
    end
  end

  initial begin
    bus.addrunit_lbuffer_en_in = 0;
    bus.addrunit_lbuffer_addr_in = '0;
    bus.addrunit_lbuffer_dest_in = '0;
    bus.addrunit_lbuffer_opcode_in = '0;
    bus.memctrl_lbuffer_rdy_in = 0;
    bus.memctrl_lbuffer_data_in = '0;
    bus.rob_lbuffer_rst_in = 0;
    #1 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_en", 32'(bus.lbuffer_memctrl_en_out), 32'd0);
    check("rst_addr", bus.lbuffer_memctrl_addr_out, 32'd0);
    check("rst_size", 32'(bus.lbuffer_memctrl_size_out), 32'd0);
    check("rst_cdb_b", 32'(bus.cdb_lbuffer_b_out), 32'd0);
    check("rst_cdb_result", bus.cdb_lbuffer_result_out, 32'd0);
    check("rst_rs_rdy", 32'(bus.lbuffer_rs_rdy_out), 32'd1);
    rst_in = 1'b0;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk_in);
      if (stall > 0) begin
        check("stall_en", 32'(bus.lbuffer_memctrl_en_out), 32'(held_en));
        check("stall_cdb", 32'(bus.cdb_lbuffer_b_out), 32'(held_b));
        stall--;
        rdy_in = (stall == 0);
        continue;
      end
      decide(c < N_CYC - N_QUIET, c < N_CYC - 12);
    end
    repeat (3) @(negedge clk_in);
    check("drained_expected", 32'(exp_q.size()), 32'd0);
    check("drained_queue", 32'(ref_q.size()), 32'd0);
    check("drained_en", 32'(bus.lbuffer_memctrl_en_out), 32'd0);
    bus.memctrl_lbuffer_rdy_in = 0;
    bus.rob_lbuffer_rst_in = 0;
    bus.addrunit_lbuffer_en_in = 1;
    bus.addrunit_lbuffer_addr_in = 32'h100;
    bus.addrunit_lbuffer_dest_in = 4'd3;
    bus.addrunit_lbuffer_opcode_in = LW;
    rdy_in = 1;
    @(negedge clk_in);
    bus.addrunit_lbuffer_en_in = 0;
    @(negedge clk_in);
    check("pre_rst_en", 32'(bus.lbuffer_memctrl_en_out), 32'd1);
    check("pre_rst_addr", bus.lbuffer_memctrl_addr_out, 32'h100);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_en", 32'(bus.lbuffer_memctrl_en_out), 32'd0);
    check("async_rst_addr", bus.lbuffer_memctrl_addr_out, 32'd0);
    check("async_rst_size", 32'(bus.lbuffer_memctrl_size_out), 32'd0);
    check("async_rst_cdb", 32'(bus.cdb_lbuffer_b_out), 32'd0);
    check("async_rst_rs_rdy", 32'(bus.lbuffer_rs_rdy_out), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
